// File: rtl/shift_reg2.sv
// Serial-in/serial-out delay line; optional stage taps when SHIFT_REG2_TAPS_EN is defined.
// Latency: DEPTH cycles from d capture to dout. No backpressure: shifts every clk edge.
module shift_reg2 #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
`ifdef SHIFT_REG2_TAPS_EN
  output logic [DEPTH-1:0] taps,
`endif
  output logic             dout
);

  generate
    if (DEPTH < 1) begin : g_depth_check
      $error("shift_reg2: DEPTH must be >= 1");
    end
  endgenerate

  // One distinct flop per stage; stage[0] captures d.
  logic [DEPTH-1:0] stage;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage <= {DEPTH{RST_VAL}};
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

`ifdef SHIFT_REG2_TAPS_EN
  assign taps = stage;
`endif

endmodule

// File: tb/tb_shift_reg2.sv
// Scoreboard bench for shift_reg2: DEPTH=2/RST_VAL=0 and DEPTH=5/RST_VAL=1 instances share stimulus.
module tb_shift_reg2;

  typedef struct packed {
    logic rst;
    logic d;
  } hist_t;

  typedef struct packed {
    logic known;
    logic val;
  } exp_t;

  logic clk;
  logic reset;
  logic d;
  logic dout2;
  logic dout5;
`ifdef SHIFT_REG2_TAPS_EN
  logic [1:0] taps2;
  logic [4:0] taps5;
`endif

  int checks = 0;
  int errors = 0;

  hist_t hist[$];
  exp_t  sb2[$];
  exp_t  sb5[$][5];

  shift_reg2 #(.DEPTH(2), .RST_VAL(1'b0)) u_d2 (
    .clk   (clk),
    .reset (reset),
    .d     (d),
`ifdef SHIFT_REG2_TAPS_EN
    .taps  (taps2),
`endif
    .dout  (dout2)
  );

  shift_reg2 #(.DEPTH(5), .RST_VAL(1'b1)) u_d5 (
    .clk   (clk),
    .reset (reset),
    .d     (d),
`ifdef SHIFT_REG2_TAPS_EN
    .taps  (taps5),
`endif
    .dout  (dout5)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Output of a dep-cycle delay line right after the newest edge in history:
  // any reset edge within the last dep edges forces rv, otherwise it is the
  // d captured dep-1 edges ago; unknown if history is too short.
  function automatic exp_t model(input int dep, input logic rv);
    exp_t e;
    int   n;
    n = hist.size();
    e.known = 1'b0;
    e.val   = 1'b0;
    for (int k = 0; k < dep; k++) begin
      if (n - 1 - k < 0) return e;
      if (hist[n-1-k].rst) begin
        e.known = 1'b1;
        e.val   = rv;
        return e;
      end
    end
    e.known = 1'b1;
    e.val   = hist[n-dep].d;
    return e;
  endfunction

  // Reference model: records each edge's inputs and queues the expected outputs.
  always @(posedge clk) begin
    hist_t h;
    exp_t  row[5];
    h.rst = (reset == 1'b0);
    h.d   = d;
    hist.push_back(h);
    if (hist.size() > 8) void'(hist.pop_front());
    sb2.push_back(model(2, 1'b0));
    for (int i = 0; i < 5; i++) row[i] = model(i + 1, 1'b1);
    sb5.push_back(row);
  end

  // Monitor: samples 1 ns after each edge and compares against queued expectations.
  always begin
    exp_t e;
    exp_t row[5];
    @(posedge clk);
    #1;
    if (sb2.size() > 0) begin
      e = sb2.pop_front();
      if (e.known) begin
        checks++;
        if (dout2 !== e.val) begin
          errors++;
          $display("FAIL dout_depth2 t=%0t got %b expected %b", $time, dout2, e.val);
        end
`ifdef SHIFT_REG2_TAPS_EN
        checks++;
        if (taps2[1] !== e.val) begin
          errors++;
          $display("FAIL taps2_msb t=%0t got %b expected %b", $time, taps2[1], e.val);
        end
`endif
      end
    end
    if (sb5.size() > 0) begin
      row = sb5.pop_front();
      if (row[4].known) begin
        checks++;
        if (dout5 !== row[4].val) begin
          errors++;
          $display("FAIL dout_depth5 t=%0t got %b expected %b", $time, dout5, row[4].val);
        end
      end
`ifdef SHIFT_REG2_TAPS_EN
      for (int i = 0; i < 5; i++) begin
        if (row[i].known) begin
          checks++;
          if (taps5[i] !== row[i].val) begin
            errors++;
            $display("FAIL taps5[%0d] t=%0t got %b expected %b", i, $time, taps5[i], row[i].val);
          end
        end
      end
`endif
    end
  end

  task automatic step(input logic r, input logic dv);
    @(negedge clk);
    reset = r;
    d     = dv;
  endtask

  initial begin
    reset = 1'b0;
    d     = 1'b1;
    // Held reset with d=1: outputs pinned at reset value.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1);
    // Release, then a single-cycle pulse.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    // Toggle every cycle.
    for (int i = 0; i < 20; i++) step(1'b1, i[0]);
    // Stream of ones with a single reset edge mid-stream.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
    // Random data with occasional reset edges.
    for (int i = 0; i < 300; i++) step(($urandom_range(15) != 0), 1'($urandom));
    // Reset then zeros: depth-5 line walks its reset ones out.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    @(posedge clk);
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
